bus_arbiter: RTL

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter_if.sv | 40 ++++
 rtl/bus_arbiter.sv | 107 ++++++++++
 2 files changed

// File: rtl/bus_arbiter_if.sv
// Bus arbiter interface: four requesters on the request side and one shared,
// slot-based bus on the arbiter side.
//
// Handshake: there is no ready/backpressure. A requester raises req_req[i]
// and holds cmd/tag/addr stable until it sees bus_grant[i] in bus_cycle 7.
// It then owns the next 8-cycle slot. bus_valid marks an owned slot, and
// bus_data carries the owner's req_data beat k during bus_cycle k. bus_nack
// reports any snoop nack seen so far in the current slot. Retrying after a
// nack is up to the requester.
interface bus_arbiter_if;
    logic [3:0]        req_req;
    logic [3:0][2:0]   req_cmd;
    logic [3:0][4:0]   req_tag;
    logic [3:0][25:0]  req_addr;
    logic [3:0][63:0]  req_data;
    logic [3:0]        snoop_nack;

    logic [3:0]        bus_grant;
    logic [2:0]        bus_cycle;
    logic              bus_valid;
    logic [2:0]        bus_cmd;
    logic [4:0]        bus_tag;
    logic [25:0]       bus_addr;
    logic [63:0]       bus_data;
    logic              bus_nack;

    // Arbiter side
    modport slave (
        input  req_req, req_cmd, req_tag, req_addr, req_data, snoop_nack,
        output bus_grant, bus_cycle, bus_valid, bus_cmd, bus_tag, bus_addr,
               bus_data, bus_nack
    );

    // Requester / agent side
    modport master (
        output req_req, req_cmd, req_tag, req_addr, req_data, snoop_nack,
        input  bus_grant, bus_cycle, bus_valid, bus_cmd, bus_tag, bus_addr,
               bus_data, bus_nack
    );
endinterface

// File: rtl/bus_arbiter.sv
// Slot-based round-robin bus arbiter for four requesters (0=L2, 1=DRAM ctrl,
// 2=IO, 3=spare).
//
// The bus runs in fixed 8-cycle slots. A free-running phase counter defines
// the slots. The grant for the next slot is decided combinationally during
// phase 7 of the current slot, so slots can run back to back with no gap.
// The owner's fields are muxed onto the bus for the whole slot, even if the
// owner drops its request partway through.
module bus_arbiter (
    input logic        clk,
    input logic        rst,
    bus_arbiter_if.slave arb
);

    logic [2:0] cycle_r;
    logic       slot_valid_r;
    logic [1:0] owner_r;
    logic [1:0] rr_ptr;
    logic       nack_r;

    logic       arb_phase;
    logic       any_req;
    logic       any_nack;
    logic [1:0] winner;
    logic       winner_found;
    logic [1:0] cand;
    logic       do_grant;

    assign arb_phase = (cycle_r == 3'd7);
    assign any_req   = |arb.req_req;
    assign any_nack  = |arb.snoop_nack;
    assign do_grant  = arb_phase & any_req;

    // Round-robin search: first requester at or above rr_ptr, modulo 4.
    always_comb begin
        winner       = rr_ptr;
        winner_found = 1'b0;
        cand         = 2'd0;
        for (int k = 0; k < 4; k++) begin
            cand = rr_ptr + 2'(k);
            if (!winner_found && arb.req_req[cand]) begin
                winner       = cand;
                winner_found = 1'b1;
            end
        end
    end

    // Free-running slot phase counter; it wraps 7->0 at each slot boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_r <= 3'd0;
        end else begin
            cycle_r <= cycle_r + 3'd1;
        end
    end

    // Slot ownership and round-robin pointer; these change only at slot boundaries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_valid_r <= 1'b0;
            owner_r      <= 2'd0;
            rr_ptr       <= 2'd0;
        end else if (arb_phase) begin
            if (any_req) begin
                slot_valid_r <= 1'b1;
                owner_r      <= winner;
                rr_ptr       <= winner + 2'd1;
            end else begin
                slot_valid_r <= 1'b0;
            end
        end
    end

    // Sticky nack within a slot. The boundary clear wins, so a nack seen
    // in phase 7 never leaks into the next slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nack_r <= 1'b0;
        end else if (arb_phase) begin
            nack_r <= 1'b0;
        end else if (slot_valid_r && any_nack) begin
            nack_r <= 1'b1;
        end
    end

    // Combinational bus outputs: grant pulse, owner field mux, nack view.
    always_comb begin
        arb.bus_grant = 4'b0000;
        if (do_grant) begin
            arb.bus_grant = 4'(4'b0001 << winner);
        end
        arb.bus_cycle = cycle_r;
        arb.bus_valid = slot_valid_r;
        arb.bus_cmd   = '0;
        arb.bus_tag   = '0;
        arb.bus_addr  = '0;
        arb.bus_data  = '0;
        if (slot_valid_r) begin
            arb.bus_cmd  = arb.req_cmd[owner_r];
            arb.bus_tag  = arb.req_tag[owner_r];
            arb.bus_addr = arb.req_addr[owner_r];
            arb.bus_data = arb.req_data[owner_r];
        end
        arb.bus_nack = slot_valid_r & (nack_r | any_nack);
    end

endmodule
